// File: rtl/nf_10g_port_stats.sv
// Per-port 10G statistics collector: saturating rx/tx/error/flap counters,
// link-state debounce and a single-cycle read port with clear-on-read.
module nf_10g_port_stats #(
  parameter int C_NUM_PORTS       = 4,
  parameter int C_PKT_CNT_WIDTH   = 32,
  parameter int C_BYTE_CNT_WIDTH  = 48,
  parameter int C_LINK_BIT        = 0,
  parameter int C_DEBOUNCE_CYCLES = 1024
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  input  logic [C_NUM_PORTS-1:0]      stat_rx_valid,
  input  logic [C_NUM_PORTS-1:0]      stat_rx_good,
  input  logic [15*C_NUM_PORTS-1:0]   stat_rx_bytes,
  input  logic [C_NUM_PORTS-1:0]      stat_tx_valid,
  input  logic [15*C_NUM_PORTS-1:0]   stat_tx_bytes,
  input  logic [8*C_NUM_PORTS-1:0]    pcspma_status,
  input  logic                        rd_req,
  input  logic [2:0]                  rd_port,
  input  logic [2:0]                  rd_sel,
  input  logic                        rd_clear,
  output logic                        rd_valid,
  output logic [63:0]                 rd_data,
  output logic [C_NUM_PORTS-1:0]      link_up,
  output logic [C_NUM_PORTS-1:0]      link_down_sticky
);

  localparam int PW = C_PKT_CNT_WIDTH;
  localparam int BW = C_BYTE_CNT_WIDTH;
  localparam int DW = $clog2(C_DEBOUNCE_CYCLES);
  // Byte sums need one spare bit above the wider of counter and frame length.
  localparam int SW = ((BW + 1) > 16) ? (BW + 1) : 16;
  localparam logic [DW-1:0] DB_LAST = DW'(C_DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DOWN      = 2'd0,
    ST_UP_PEND   = 2'd1,
    ST_UP        = 2'd2,
    ST_DOWN_PEND = 2'd3
  } link_state_e;

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v, input logic inc);
    if (inc && (v != {PW{1'b1}})) begin
      return v + PW'(1);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [BW-1:0] sat_add(input logic [BW-1:0] v, input logic [14:0] add);
    logic [SW-1:0] sum;
    sum = SW'(v) + SW'(add);
    if (sum > SW'({BW{1'b1}})) begin
      return {BW{1'b1}};
    end else begin
      return sum[BW-1:0];
    end
  endfunction

  logic [PW-1:0] rx_pkts_q  [C_NUM_PORTS];
  logic [PW-1:0] rx_bad_q   [C_NUM_PORTS];
  logic [BW-1:0] rx_bytes_q [C_NUM_PORTS];
  logic [PW-1:0] tx_pkts_q  [C_NUM_PORTS];
  logic [BW-1:0] tx_bytes_q [C_NUM_PORTS];
  logic [PW-1:0] flaps_q    [C_NUM_PORTS];
  logic [PW-1:0] rx_pkts_d  [C_NUM_PORTS];
  logic [PW-1:0] rx_bad_d   [C_NUM_PORTS];
  logic [BW-1:0] rx_bytes_d [C_NUM_PORTS];
  logic [PW-1:0] tx_pkts_d  [C_NUM_PORTS];
  logic [BW-1:0] tx_bytes_d [C_NUM_PORTS];
  logic [PW-1:0] flaps_d    [C_NUM_PORTS];

  link_state_e              st_q       [C_NUM_PORTS];
  logic [DW-1:0]            dcnt_q     [C_NUM_PORTS];
  logic [DW-1:0]            dcnt_inc_s [C_NUM_PORTS];
  logic [C_NUM_PORTS-1:0]   lnk_s;
  logic [C_NUM_PORTS-1:0]   fall_s;
  logic [C_NUM_PORTS-1:0]   link_up_q;
  logic [C_NUM_PORTS-1:0]   sticky_q;
  logic [C_NUM_PORTS-1:0]   sticky_d;

  logic                     rd_in_range_s;
  logic                     rd_clr_s;
  logic [C_NUM_PORTS-1:0]   clr_port_s;
  logic [7:0]               clr_sel_s;
  logic [63:0]              sel_word_s;
  logic [63:0]              rd_val_s;
  logic                     rd_valid_q;
  logic [63:0]              rd_data_q;

  assign rd_in_range_s = ({29'd0, rd_port} < 32'(C_NUM_PORTS)) && (rd_sel != 3'd7);
  assign rd_clr_s      = rd_req && rd_clear && rd_in_range_s;
  assign clr_sel_s     = rd_clr_s ? (8'd1 << rd_sel) : 8'd0;

  // Link bit extraction, debounce counter increment and debounced-fall detect.
  always_comb begin
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      lnk_s[p]      = pcspma_status[8*p + C_LINK_BIT];
      dcnt_inc_s[p] = dcnt_q[p] + DW'(1);
      fall_s[p]     = (st_q[p] == ST_DOWN_PEND) && !lnk_s[p] && (dcnt_inc_s[p] == DB_LAST);
      clr_port_s[p] = rd_clr_s && (rd_port == 3'(p));
    end
  end

  // Next counter values: a clear drops the old value but keeps this cycle's event.
  always_comb begin
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      rx_pkts_d[p]  = sat_inc((clr_port_s[p] && clr_sel_s[0]) ? {PW{1'b0}} : rx_pkts_q[p],
                              stat_rx_valid[p]);
      rx_bad_d[p]   = sat_inc((clr_port_s[p] && clr_sel_s[1]) ? {PW{1'b0}} : rx_bad_q[p],
                              stat_rx_valid[p] && !stat_rx_good[p]);
      rx_bytes_d[p] = sat_add((clr_port_s[p] && clr_sel_s[2]) ? {BW{1'b0}} : rx_bytes_q[p],
                              stat_rx_valid[p] ? stat_rx_bytes[15*p +: 15] : 15'd0);
      tx_pkts_d[p]  = sat_inc((clr_port_s[p] && clr_sel_s[3]) ? {PW{1'b0}} : tx_pkts_q[p],
                              stat_tx_valid[p]);
      tx_bytes_d[p] = sat_add((clr_port_s[p] && clr_sel_s[4]) ? {BW{1'b0}} : tx_bytes_q[p],
                              stat_tx_valid[p] ? stat_tx_bytes[15*p +: 15] : 15'd0);
      flaps_d[p]    = sat_inc((clr_port_s[p] && clr_sel_s[5]) ? {PW{1'b0}} : flaps_q[p],
                              fall_s[p]);
      // A fall landing together with the clear wins, so the sticky stays set.
      sticky_d[p]   = fall_s[p] ? 1'b1 :
                      ((clr_port_s[p] && clr_sel_s[5]) ? 1'b0 : sticky_q[p]);
    end
  end

  // Counter and sticky registers.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        rx_pkts_q[p]  <= {PW{1'b0}};
        rx_bad_q[p]   <= {PW{1'b0}};
        rx_bytes_q[p] <= {BW{1'b0}};
        tx_pkts_q[p]  <= {PW{1'b0}};
        tx_bytes_q[p] <= {BW{1'b0}};
        flaps_q[p]    <= {PW{1'b0}};
      end
      sticky_q <= {C_NUM_PORTS{1'b0}};
    end else begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        rx_pkts_q[p]  <= rx_pkts_d[p];
        rx_bad_q[p]   <= rx_bad_d[p];
        rx_bytes_q[p] <= rx_bytes_d[p];
        tx_pkts_q[p]  <= tx_pkts_d[p];
        tx_bytes_q[p] <= tx_bytes_d[p];
        flaps_q[p]    <= flaps_d[p];
      end
      sticky_q <= sticky_d;
    end
  end

  // Per-port link debounce FSM with registered link_up.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        st_q[p]   <= ST_DOWN;
        dcnt_q[p] <= {DW{1'b0}};
      end
      link_up_q <= {C_NUM_PORTS{1'b0}};
    end else begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        case (st_q[p])
          ST_DOWN: begin
            if (lnk_s[p]) begin
              st_q[p]   <= ST_UP_PEND;
              dcnt_q[p] <= {DW{1'b0}};
            end
          end
          ST_UP_PEND: begin
            if (!lnk_s[p]) begin
              st_q[p] <= ST_DOWN;
            end else if (dcnt_inc_s[p] == DB_LAST) begin
              st_q[p]      <= ST_UP;
              link_up_q[p] <= 1'b1;
            end else begin
              dcnt_q[p] <= dcnt_inc_s[p];
            end
          end
          ST_UP: begin
            if (!lnk_s[p]) begin
              st_q[p]   <= ST_DOWN_PEND;
              dcnt_q[p] <= {DW{1'b0}};
            end
          end
          ST_DOWN_PEND: begin
            if (lnk_s[p]) begin
              st_q[p] <= ST_UP;
            end else if (dcnt_inc_s[p] == DB_LAST) begin
              st_q[p]      <= ST_DOWN;
              link_up_q[p] <= 1'b0;
            end else begin
              dcnt_q[p] <= dcnt_inc_s[p];
            end
          end
          default: begin
            st_q[p]      <= ST_DOWN;
            dcnt_q[p]    <= {DW{1'b0}};
            link_up_q[p] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read mux: OR of per-port selected words, only the addressed port contributes.
  always_comb begin
    rd_val_s   = 64'd0;
    sel_word_s = 64'd0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      case (rd_sel)
        3'd0:    sel_word_s = 64'(rx_pkts_q[p]);
        3'd1:    sel_word_s = 64'(rx_bad_q[p]);
        3'd2:    sel_word_s = 64'(rx_bytes_q[p]);
        3'd3:    sel_word_s = 64'(tx_pkts_q[p]);
        3'd4:    sel_word_s = 64'(tx_bytes_q[p]);
        3'd5:    sel_word_s = 64'(flaps_q[p]);
        3'd6:    sel_word_s = {50'd0, sticky_q[p], link_up_q[p], 2'b00, st_q[p],
                               pcspma_status[8*p +: 8]};
        default: sel_word_s = 64'd0;
      endcase
      rd_val_s = rd_val_s | ((rd_port == 3'(p)) ? sel_word_s : 64'd0);
    end
  end

  // Read response register; data holds when no request is made.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 64'd0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= rd_in_range_s ? rd_val_s : 64'd0;
      end
    end
  end

  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign link_up          = link_up_q;
  assign link_down_sticky = sticky_q;

endmodule

// File: tb/tb_nf_10g_port_stats.sv
// Self-checking bench: directed scenarios plus random traffic against a
// run-length / saturating-arithmetic reference model.
module tb_nf_10g_port_stats;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int BW = 16;
  localparam int LB = 0;
  localparam int DB = 16;
  localparam longint PMAX = (64'sd1 <<< PW) - 64'sd1;
  localparam longint BMAX = (64'sd1 <<< BW) - 64'sd1;

  logic                 axis_aclk = 1'b0;
  logic                 axis_aresetn;
  logic [NP-1:0]        stat_rx_valid, stat_rx_good, stat_tx_valid;
  logic [15*NP-1:0]     stat_rx_bytes, stat_tx_bytes;
  logic [8*NP-1:0]      pcspma_status;
  logic                 rd_req, rd_clear;
  logic [2:0]           rd_port, rd_sel;
  logic                 rd_valid;
  logic [63:0]          rd_data;
  logic [NP-1:0]        link_up, link_down_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counters indexed by read select, link as (state, run of disagreeing samples)
  longint      m_cnt [NP][6];
  bit          m_up [NP];
  bit          m_sticky [NP];
  int          m_run [NP];
  logic [63:0] exp_rd_data;
  logic        exp_rd_valid;
  int          hold [NP];

  nf_10g_port_stats #(
    .C_NUM_PORTS(NP), .C_PKT_CNT_WIDTH(PW), .C_BYTE_CNT_WIDTH(BW),
    .C_LINK_BIT(LB), .C_DEBOUNCE_CYCLES(DB)
  ) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .stat_rx_valid(stat_rx_valid), .stat_rx_good(stat_rx_good), .stat_rx_bytes(stat_rx_bytes),
    .stat_tx_valid(stat_tx_valid), .stat_tx_bytes(stat_tx_bytes),
    .pcspma_status(pcspma_status),
    .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_clear(rd_clear),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .link_up(link_up), .link_down_sticky(link_down_sticky)
  );

  always #5 axis_aclk = ~axis_aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < 6; s++) m_cnt[p][s] = 0;
      m_up[p] = 1'b0; m_sticky[p] = 1'b0; m_run[p] = 0;
    end
    exp_rd_data = 64'd0; exp_rd_valid = 1'b0;
  endtask

  function automatic logic [63:0] model_read(input int p, input int s);
    logic [1:0] st;
    if (p >= NP || s == 7) return 64'd0;
    if (s == 6) begin
      st = m_up[p] ? ((m_run[p] > 0) ? 2'd3 : 2'd2) : ((m_run[p] > 0) ? 2'd1 : 2'd0);
      return {50'd0, m_sticky[p], m_up[p], 2'b00, st, pcspma_status[8*p +: 8]};
    end
    return 64'(m_cnt[p][s]);
  endfunction

  task automatic idle();
    stat_rx_valid = '0; stat_rx_good = '0; stat_tx_valid = '0;
    rd_req = 1'b0; rd_clear = 1'b0;
  endtask

  // One clock: model consumes the currently driven inputs, then DUT outputs are compared.
  task automatic tick();
    longint inc [6];
    longint base, lim;
    bit clr_ok, fell, lb;
    logic [NP-1:0] e_up, e_st;
    exp_rd_valid = rd_req;
    if (rd_req) exp_rd_data = model_read(int'(rd_port), int'(rd_sel));
    clr_ok = rd_req && rd_clear && (int'(rd_port) < NP) && (rd_sel < 3'd6);
    for (int p = 0; p < NP; p++) begin
      inc[0] = longint'(stat_rx_valid[p]);
      inc[1] = longint'(stat_rx_valid[p] && !stat_rx_good[p]);
      inc[2] = stat_rx_valid[p] ? longint'(stat_rx_bytes[15*p +: 15]) : 0;
      inc[3] = longint'(stat_tx_valid[p]);
      inc[4] = stat_tx_valid[p] ? longint'(stat_tx_bytes[15*p +: 15]) : 0;
      fell = 1'b0;
      lb = pcspma_status[8*p + LB];
      if (lb != m_up[p]) begin
        m_run[p]++;
        if (m_run[p] == DB) begin
          m_up[p] = lb; m_run[p] = 0; fell = !lb;
        end
      end else m_run[p] = 0;
      inc[5] = longint'(fell);
      for (int s = 0; s < 6; s++) begin
        base = (clr_ok && int'(rd_port) == p && int'(rd_sel) == s) ? 0 : m_cnt[p][s];
        lim  = (s == 2 || s == 4) ? BMAX : PMAX;
        m_cnt[p][s] = (base + inc[s] > lim) ? lim : base + inc[s];
      end
      if (fell) m_sticky[p] = 1'b1;
      else if (clr_ok && int'(rd_port) == p && rd_sel == 3'd5) m_sticky[p] = 1'b0;
    end
    @(posedge axis_aclk); #1;
    for (int p = 0; p < NP; p++) begin
      e_up[p] = m_up[p]; e_st[p] = m_sticky[p];
    end
    chk("rd_valid", 64'(rd_valid), 64'(exp_rd_valid));
    chk("rd_data", rd_data, exp_rd_data);
    chk("link_up", 64'(link_up), 64'(e_up));
    chk("link_down_sticky", 64'(link_down_sticky), 64'(e_st));
  endtask

  task automatic rx(input int p, input bit good, input int bytes);
    stat_rx_valid[p] = 1'b1; stat_rx_good[p] = good;
    stat_rx_bytes[15*p +: 15] = 15'(bytes);
    tick();
    stat_rx_valid[p] = 1'b0;
  endtask

  task automatic tx(input int p, input int bytes);
    stat_tx_valid[p] = 1'b1; stat_tx_bytes[15*p +: 15] = 15'(bytes);
    tick();
    stat_tx_valid[p] = 1'b0;
  endtask

  task automatic read_op(input int p, input int s, input bit clr);
    rd_req = 1'b1; rd_port = 3'(p); rd_sel = 3'(s); rd_clear = clr;
    tick();
    rd_req = 1'b0; rd_clear = 1'b0;
  endtask

  initial begin
    axis_aresetn = 1'b0;
    idle();
    stat_rx_bytes = '0; stat_tx_bytes = '0; pcspma_status = '0;
    rd_port = 3'd0; rd_sel = 3'd0;
    model_reset();
    #1;
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_link_up", 64'(link_up), 64'd0);
    chk("reset_sticky", 64'(link_down_sticky), 64'd0);
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk); axis_aresetn = 1'b1;

    // rx accounting on port 0
    rx(0, 1'b1, 64); rx(0, 1'b1, 1518); rx(0, 1'b1, 60); rx(0, 1'b0, 100);
    read_op(0, 0, 1'b0); chk("rx_pkts_4", rd_data, 64'd4);
    read_op(0, 1, 1'b0); chk("rx_bad_1", rd_data, 64'd1);
    read_op(0, 2, 1'b0); chk("rx_bytes_1742", rd_data, 64'd1742);

    // clear-on-read racing an rx strobe
    stat_rx_valid[0] = 1'b1; stat_rx_good[0] = 1'b1; stat_rx_bytes[14:0] = 15'd64;
    read_op(0, 0, 1'b1);
    stat_rx_valid[0] = 1'b0;
    chk("clr_old_value", rd_data, 64'd4);
    read_op(0, 0, 1'b0); chk("clr_keeps_event", rd_data, 64'd1);

    // debounce on port 1
    pcspma_status[8+LB] = 1'b1; repeat (15) tick();
    pcspma_status[8+LB] = 1'b0; tick();
    chk("up_after_15", 64'(link_up[1]), 64'd0);
    pcspma_status[8+LB] = 1'b1; repeat (16) tick();
    chk("up_after_16", 64'(link_up[1]), 64'd1);
    pcspma_status[8+LB] = 1'b0; repeat (10) tick();
    pcspma_status[8+LB] = 1'b1; tick();
    chk("glitch_stays_up", 64'(link_up[1]), 64'd1);
    read_op(1, 5, 1'b0); chk("glitch_no_flap", rd_data, 64'd0);
    pcspma_status[8+LB] = 1'b0; repeat (15) tick();
    chk("down_pend_15", 64'(link_up[1]), 64'd1);
    tick();
    chk("down_after_16", 64'(link_up[1]), 64'd0);
    chk("sticky_set", 64'(link_down_sticky[1]), 64'd1);
    read_op(1, 5, 1'b0); chk("flaps_1", rd_data, 64'd1);
    read_op(1, 6, 1'b0); chk("status_word", rd_data, 64'h2000);
    read_op(1, 5, 1'b1); chk("flaps_clr_old", rd_data, 64'd1);
    chk("sticky_cleared", 64'(link_down_sticky[1]), 64'd0);
    read_op(1, 5, 1'b0); chk("flaps_after_clr", rd_data, 64'd0);
    // fall coinciding with a sel-5 clear
    pcspma_status[8+LB] = 1'b1; repeat (16) tick();
    pcspma_status[8+LB] = 1'b0; repeat (15) tick();
    read_op(1, 5, 1'b1); chk("fall_clr_old", rd_data, 64'd0);
    chk("fall_clr_sticky", 64'(link_down_sticky[1]), 64'd1);
    read_op(1, 5, 1'b0); chk("fall_clr_flaps", rd_data, 64'd1);

    // saturation
    repeat (254) tx(2, 100);
    read_op(2, 3, 1'b0); chk("tx_pkts_254", rd_data, 64'd254);
    repeat (3) tx(2, 100);
    read_op(2, 3, 1'b0); chk("tx_pkts_sat", rd_data, 64'd255);
    repeat (50) rx(3, 1'b1, 1500);
    read_op(3, 2, 1'b0); chk("rx_bytes_sat", rd_data, 64'd65535);

    // out-of-range reads
    read_op(5, 0, 1'b1);
    chk("oob_valid", 64'(rd_valid), 64'd1); chk("oob_data", rd_data, 64'd0);
    read_op(0, 7, 1'b1); chk("sel7_data", rd_data, 64'd0);
    read_op(0, 0, 1'b0); chk("oob_no_clear", rd_data, 64'd1);

    // random traffic against the model
    for (int p = 0; p < NP; p++) hold[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        stat_rx_valid[p] = ($urandom_range(0, 3) == 0);
        stat_rx_good[p]  = ($urandom_range(0, 4) != 0);
        stat_rx_bytes[15*p +: 15] = 15'($urandom_range(40, 9600));
        stat_tx_valid[p] = ($urandom_range(0, 3) == 0);
        stat_tx_bytes[15*p +: 15] = 15'($urandom_range(40, 9600));
        if (hold[p] == 0) begin
          pcspma_status[8*p +: 8] = 8'($urandom_range(0, 255));
          hold[p] = $urandom_range(1, 40);
        end else hold[p]--;
      end
      rd_req   = ($urandom_range(0, 1) == 1);
      rd_port  = 3'($urandom_range(0, 5));
      rd_sel   = 3'($urandom_range(0, 7));
      rd_clear = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle();

    // reset in the middle of a read with the link up
    pcspma_status = '0; pcspma_status[LB] = 1'b1;
    repeat (2 * DB) tick();
    chk("pre_reset_up", 64'(link_up[0]), 64'd1);
    rd_req = 1'b1; rd_port = 3'd0; rd_sel = 3'd2;
    tick();
    #2; axis_aresetn = 1'b0; #1;
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_rd_data", rd_data, 64'd0);
    chk("arst_link_up", 64'(link_up), 64'd0);
    chk("arst_sticky", 64'(link_down_sticky), 64'd0);
    model_reset();
    idle(); pcspma_status = '0;
    @(negedge axis_aclk); axis_aresetn = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < 6; s++) read_op(p, s, 1'b0);
    read_op(2, 3, 1'b0); chk("post_reset_tx_pkts", rd_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
